// File: rtl/servo_pkg.sv
// Shared definitions for the servo command scheduler: FSM encoding,
// default angle ceiling and the millisecond tick prescale.
package servo_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    HOLD   = ST_HOLD
  } state_t;

  localparam logic [7:0] MAX_ANGLE_DEF = 8'd180;

  // Clock cycles per millisecond; never below one so the timer always advances.
  function automatic logic [23:0] ms_prescale(input logic [23:0] clk_fre);
    return (clk_fre < 24'd1000) ? 24'd1 : clk_fre / 24'd1000;
  endfunction

endpackage

// File: rtl/servo_ms_timer.sv
// Millisecond interval timer: load a target in ms, expire flags the final
// cycle of the interval; expire_nxt is what expire will be after this edge.
module servo_ms_timer
  import servo_pkg::*;
#(
  parameter logic [23:0] CLK_FRE = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] target,
  output logic        expire,
  output logic        expire_nxt
);

  localparam logic [23:0] TICKS = ms_prescale(CLK_FRE);

  logic [23:0] presc;
  logic [23:0] presc_nxt;
  logic [15:0] ms_cnt;
  logic [15:0] ms_nxt;
  logic [15:0] target_q;

  // A zero target still occupies one cycle; otherwise the interval ends on
  // the last prescaler count of the last millisecond.
  always_comb begin
    presc_nxt = presc + 24'd1;
    ms_nxt    = ms_cnt;
    if (presc == TICKS - 24'd1) begin
      presc_nxt = '0;
      ms_nxt    = ms_cnt + 16'd1;
    end
    expire_nxt = (ms_nxt == target_q - 16'd1) && (presc_nxt == TICKS - 24'd1);
    if (load) begin
      expire_nxt = (target == 16'd0) || ((target == 16'd1) && (TICKS == 24'd1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      ms_cnt   <= '0;
      target_q <= '0;
      expire   <= 1'b0;
    end else if (load) begin
      presc    <= '0;
      ms_cnt   <= '0;
      target_q <= target;
      expire   <= expire_nxt;
    end else begin
      presc    <= presc_nxt;
      ms_cnt   <= ms_nxt;
      expire   <= expire_nxt;
    end
  end

endmodule

// File: rtl/servo_cmd_sched.sv
// Round-robin scheduler sharing one pwm_servo between two command ports;
// holds the grant through slew settle time plus a fixed dwell.
module servo_cmd_sched
  import servo_pkg::*;
#(
  parameter logic [23:0] CLK_FRE    = 24'd12_000_000,
  parameter logic [7:0]  MS_PER_DEG = 8'd10,
  parameter logic [15:0] HOLD_MS    = 16'd100,
  parameter logic [7:0]  MAX_ANGLE  = MAX_ANGLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_angle,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_angle,
  output logic       req1_ready,
  output logic [7:0] cfg,
  output logic       busy,
  output logic       done,
  output logic       owner
);

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        grant;
  logic        accept;
  logic        load;
  logic        expire;
  logic        expire_nxt;
  logic [7:0]  angle_sel;
  logic [7:0]  angle_clamped;
  logic [15:0] settle_ms;
  logic [15:0] tmr_target;

  function automatic logic [7:0] clamp_angle(input logic [7:0] a);
    return (a > MAX_ANGLE) ? MAX_ANGLE : a;
  endfunction

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // owner and last_grant always carry the same value, so one register serves both.
  assign owner = last_grant;
  assign busy  = (state != IDLE);

  // With no contention the grant points at whoever would win a tie.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req0_valid)          grant = 1'b0;
    else if (req1_valid)          grant = 1'b1;
    else                          grant = ~last_grant;
  end

  assign req0_ready    = (state == IDLE) && !grant;
  assign req1_ready    = (state == IDLE) && grant;
  assign accept        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign angle_sel     = grant ? req1_angle : req0_angle;
  assign angle_clamped = clamp_angle(angle_sel);
  assign settle_ms     = 16'(abs_diff(angle_clamped, cfg)) * 16'(MS_PER_DEG);

  // One timer serves both phases: reloaded at accept and at SETTLE->HOLD.
  assign load       = accept || ((state == SETTLE) && expire);
  assign tmr_target = accept ? settle_ms : HOLD_MS;

  servo_ms_timer #(
    .CLK_FRE (CLK_FRE)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .target     (tmr_target),
    .expire     (expire),
    .expire_nxt (expire_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETTLE;
      SETTLE:  if (expire) state_nxt = HOLD;
      HOLD:    if (expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done is registered so it lines up exactly with the final HOLD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cfg        <= '0;
      done       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == HOLD) && expire_nxt;
      if (accept) begin
        cfg        <= angle_clamped;
        last_grant <= grant;
      end
    end
  end

endmodule
